// File: rtl/parallax_pkg.sv
// Shared definitions for the parallax scroll controller: register map,
// FSM state encoding and reset defaults.
package parallax_pkg;

  localparam logic [3:0]  REG_CTRL       = 4'd0;
  localparam logic [3:0]  REG_SPEED_BASE = 4'd1;
  localparam logic [3:0]  REG_SEED_BASE  = 4'd5;
  localparam logic [3:0]  REG_DIV        = 4'd9;

  localparam logic [15:0] RESET_SEED     = 16'hACE1;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_COMMIT = 2'd1,
    ST_STEP   = 2'd2,
    ST_LOAD   = 2'd3
  } state_e;

  // Layer i scrolls by i+1 pixels per stepped frame out of reset.
  function automatic logic [7:0] default_speed(input int unsigned idx);
    logic [7:0] v;
    v = 8'(idx) + 8'd1;
    return v;
  endfunction

endpackage

// File: rtl/parallax_cfg_regs.sv
// Shadow configuration registers for the parallax controller. Holds the
// values written over the cfg port until the frame scheduler commits them,
// tracks which layer seeds have been rewritten, and owns cfg_ready.
module parallax_cfg_regs
  import parallax_pkg::*;
#(
  parameter int NUM_LAYERS = 3,
  parameter int SEED_W     = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         i_commit_next,
  input  logic                         i_commit,
  input  logic                         i_cfg_valid,
  input  logic [3:0]                   i_cfg_addr,
  input  logic [15:0]                  i_cfg_data,
  output logic                         o_cfg_ready,
  output logic                         o_global_en,
  output logic [NUM_LAYERS-1:0]        o_layer_en,
  output logic                         o_pause,
  output logic [NUM_LAYERS*8-1:0]      o_speed,
  output logic [NUM_LAYERS*SEED_W-1:0] o_seed,
  output logic [3:0]                   o_divider,
  output logic [NUM_LAYERS-1:0]        o_dirty
);

  logic                                r_ready;
  logic                                r_global_en;
  logic                                r_pause;
  logic [NUM_LAYERS-1:0]               r_layer_en;
  logic [NUM_LAYERS-1:0]               r_dirty;
  logic [NUM_LAYERS-1:0][7:0]          r_speed;
  logic [NUM_LAYERS-1:0][SEED_W-1:0]   r_seed;
  logic [3:0]                          r_divider;

  logic                                w_fire;
  logic [NUM_LAYERS-1:0]               w_speed_hit;
  logic [NUM_LAYERS-1:0]               w_seed_hit;
  logic [SEED_W-1:0]                   w_seed_val;

  assign w_fire     = i_cfg_valid && r_ready;
  // An all-zero seed would lock the LFSR, so it is replaced by 1.
  assign w_seed_val = (i_cfg_data[SEED_W-1:0] == {SEED_W{1'b0}}) ?
                      {{(SEED_W-1){1'b0}}, 1'b1} : i_cfg_data[SEED_W-1:0];

  // Decode per-layer speed and seed register hits for an accepted write.
  always_comb begin
    w_speed_hit = '0;
    w_seed_hit  = '0;
    for (int i = 0; i < NUM_LAYERS; i++) begin
      w_speed_hit[i] = w_fire && (i_cfg_addr == REG_SPEED_BASE + 4'(i));
      w_seed_hit[i]  = w_fire && (i_cfg_addr == REG_SEED_BASE + 4'(i));
    end
  end

  // Ready is dropped for exactly the cycle the scheduler spends in COMMIT.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_ready <= 1'b1;
    else        r_ready <= !i_commit_next;
  end

  // Shadow register file: an accepted write lands at the accepting edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_global_en <= 1'b1;
      r_layer_en  <= '1;
      r_pause     <= 1'b0;
      r_divider   <= 4'd0;
      for (int i = 0; i < NUM_LAYERS; i++) begin
        r_speed[i] <= default_speed(i);
        r_seed[i]  <= SEED_W'(RESET_SEED);
      end
    end else begin
      if (w_fire && (i_cfg_addr == REG_CTRL)) begin
        r_global_en <= i_cfg_data[0];
        r_layer_en  <= i_cfg_data[NUM_LAYERS:1];
        r_pause     <= i_cfg_data[8];
      end
      if (w_fire && (i_cfg_addr == REG_DIV)) r_divider <= i_cfg_data[3:0];
      for (int i = 0; i < NUM_LAYERS; i++) begin
        if (w_speed_hit[i]) r_speed[i] <= i_cfg_data[7:0];
        if (w_seed_hit[i])  r_seed[i]  <= w_seed_val;
      end
    end
  end

  // Dirty bits: handed to the scheduler at commit; later writes belong to the next frame.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)        r_dirty <= '0;
    else if (i_commit) r_dirty <= w_seed_hit;
    else               r_dirty <= r_dirty | w_seed_hit;
  end

  assign o_cfg_ready = r_ready;
  assign o_global_en = r_global_en;
  assign o_layer_en  = r_layer_en;
  assign o_pause     = r_pause;
  assign o_speed     = r_speed;
  assign o_seed      = r_seed;
  assign o_divider   = r_divider;
  assign o_dirty     = r_dirty;

endmodule

// File: rtl/parallax_scroll_ctrl.sv
// Per-frame scheduler for the LFSR parallax layers. At the start of vertical
// blanking it commits the shadow configuration to the live outputs, steps
// each layer's scroll position (subject to pause and the frame divider) and
// pulses seed_load for layers whose seed was rewritten.
module parallax_scroll_ctrl
  import parallax_pkg::*;
#(
  parameter int NUM_LAYERS = 3,
  parameter int V_ACTIVE   = 480,
  parameter int SCROLL_W   = 10,
  parameter int SEED_W     = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [9:0]                   hpos,
  input  logic [9:0]                   vpos,
  input  logic                         cfg_valid,
  output logic                         cfg_ready,
  input  logic [3:0]                   cfg_addr,
  input  logic [15:0]                  cfg_data,
  output logic [NUM_LAYERS-1:0]        layer_en,
  output logic [NUM_LAYERS*SCROLL_W-1:0] scroll_x,
  output logic [NUM_LAYERS*SEED_W-1:0] layer_seed,
  output logic [NUM_LAYERS-1:0]        seed_load,
  output logic [7:0]                   frame_count,
  output logic                         busy
);

  localparam logic [1:0] K_LAST = 2'(NUM_LAYERS - 1);
  localparam logic [9:0] TRIG_V = 10'(V_ACTIVE);

  state_e                              r_state;
  state_e                              w_next_state;
  logic [1:0]                          r_k;
  logic [3:0]                          r_div_cnt;
  logic [7:0]                          r_frame;
  logic [NUM_LAYERS-1:0]               r_layer_en;
  logic [NUM_LAYERS-1:0][SCROLL_W-1:0] r_scroll;
  logic [NUM_LAYERS-1:0][7:0]          r_speed;
  logic [NUM_LAYERS-1:0][SEED_W-1:0]   r_seed;
  logic [NUM_LAYERS-1:0]               r_pend;
  logic [NUM_LAYERS-1:0]               r_seed_load;
  logic                                r_busy;

  logic                                w_trigger;
  logic                                w_do_step;
  logic [SCROLL_W-1:0]                 w_step_sum;
  logic [NUM_LAYERS-1:0]               w_load_src;
  logic                                w_sh_global;
  logic [NUM_LAYERS-1:0]               w_sh_en;
  logic                                w_sh_pause;
  logic [NUM_LAYERS*8-1:0]             w_sh_speed;
  logic [NUM_LAYERS*SEED_W-1:0]        w_sh_seed;
  logic [3:0]                          w_sh_div;
  logic [NUM_LAYERS-1:0]               w_dirty;

  parallax_cfg_regs #(
    .NUM_LAYERS (NUM_LAYERS),
    .SEED_W     (SEED_W)
  ) u_cfg_regs (
    .clk           (clk),
    .reset         (reset),
    .i_commit_next (w_next_state == ST_COMMIT),
    .i_commit      (r_state == ST_COMMIT),
    .i_cfg_valid   (cfg_valid),
    .i_cfg_addr    (cfg_addr),
    .i_cfg_data    (cfg_data),
    .o_cfg_ready   (cfg_ready),
    .o_global_en   (w_sh_global),
    .o_layer_en    (w_sh_en),
    .o_pause       (w_sh_pause),
    .o_speed       (w_sh_speed),
    .o_seed        (w_sh_seed),
    .o_divider     (w_sh_div),
    .o_dirty       (w_dirty)
  );

  assign w_trigger  = (hpos == 10'd0) && (vpos == TRIG_V);
  assign w_do_step  = !w_sh_pause && (r_div_cnt == w_sh_div);
  assign w_step_sum = r_scroll[r_k] + SCROLL_W'($signed(r_speed[r_k]));
  // Skipped frames go COMMIT->LOAD directly, before r_pend has been captured.
  assign w_load_src = (r_state == ST_COMMIT) ? w_dirty : r_pend;

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= ST_RUN;
    else        r_state <= w_next_state;
  end

  // Next-state logic; a trigger outside RUN is ignored.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_RUN: begin
        if (w_trigger) w_next_state = ST_COMMIT;
        else           w_next_state = ST_RUN;
      end
      ST_COMMIT: begin
        if (w_do_step) w_next_state = ST_STEP;
        else           w_next_state = ST_LOAD;
      end
      ST_STEP: begin
        if (r_k == K_LAST) w_next_state = ST_LOAD;
        else               w_next_state = ST_STEP;
      end
      ST_LOAD: w_next_state = ST_RUN;
      default: w_next_state = ST_RUN;
    endcase
  end

  // Live registers: commit snapshot, frame/divider counters and scroll stepping.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_k        <= 2'd0;
      r_div_cnt  <= 4'd0;
      r_frame    <= 8'd0;
      r_layer_en <= '1;
      r_pend     <= '0;
      for (int i = 0; i < NUM_LAYERS; i++) begin
        r_scroll[i] <= '0;
        r_speed[i]  <= default_speed(i);
        r_seed[i]   <= SEED_W'(RESET_SEED);
      end
    end else begin
      case (r_state)
        ST_COMMIT: begin
          r_layer_en <= w_sh_en & {NUM_LAYERS{w_sh_global}};
          r_speed    <= w_sh_speed;
          r_seed     <= w_sh_seed;
          r_frame    <= r_frame + 8'd1;
          r_pend     <= w_dirty;
          r_k        <= 2'd0;
          if (w_do_step)        r_div_cnt <= 4'd0;
          else if (!w_sh_pause) r_div_cnt <= r_div_cnt + 4'd1;
        end
        ST_STEP: begin
          r_scroll[r_k] <= w_step_sum;
          r_k           <= r_k + 2'd1;
        end
        default: ;
      endcase
    end
  end

  // Registered status outputs: busy outside RUN, seed_load only during LOAD.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_busy      <= 1'b0;
      r_seed_load <= '0;
    end else begin
      r_busy      <= (w_next_state != ST_RUN);
      r_seed_load <= (w_next_state == ST_LOAD) ? w_load_src : '0;
    end
  end

  assign layer_en    = r_layer_en;
  assign scroll_x    = r_scroll;
  assign layer_seed  = r_seed;
  assign seed_load   = r_seed_load;
  assign frame_count = r_frame;
  assign busy        = r_busy;

endmodule
